// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Function : Multi-cycle fetch/decode/execute/memory/write-back sequencer
//            for an RV32I-style core, with retire counter and halt/error flags.
// Revision : 1.0
// ============================================================================
module multicycle_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             branch_lt,
    output logic             branch_ge,
    output logic             branch_u,
    output logic             jump,
    output logic [2:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired_count
);

    localparam int              TO_W    = $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [3:0] CLS_NONE   = 4'd0;
    localparam logic [3:0] CLS_R      = 4'd1;
    localparam logic [3:0] CLS_I      = 4'd2;
    localparam logic [3:0] CLS_LOAD   = 4'd3;
    localparam logic [3:0] CLS_STORE  = 4'd4;
    localparam logic [3:0] CLS_BRANCH = 4'd5;
    localparam logic [3:0] CLS_JAL    = 4'd6;
    localparam logic [3:0] CLS_JALR   = 4'd7;
    localparam logic [3:0] CLS_LUI    = 4'd8;
    localparam logic [3:0] CLS_AUIPC  = 4'd9;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0]       state_q,   state_d;
    logic [3:0]       cls_q,     cls_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [3:0]       w_cls;
    logic             w_br_ok;

    always_comb begin
        w_cls = CLS_NONE;
        case (opcode)
            7'b0110011: w_cls = CLS_R;
            7'b0010011: w_cls = CLS_I;
            7'b0000011: w_cls = CLS_LOAD;
            7'b0100011: w_cls = CLS_STORE;
            7'b1100011: w_cls = CLS_BRANCH;
            7'b1101111: w_cls = CLS_JAL;
            7'b1100111: w_cls = CLS_JALR;
            7'b0110111: w_cls = CLS_LUI;
            7'b0010111: w_cls = CLS_AUIPC;
            default:    w_cls = CLS_NONE;
        endcase
    end

    // funct3 010/011 are the only undefined branch encodings
    assign w_br_ok = (funct3[2:1] != 2'b01);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_NONE;
            timeout_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready)              state_d = S_DECODE;
                else if (timeout_q == TO_LAST) state_d = S_ERROR;
                else                         timeout_d = timeout_q + 1'b1;
            end
            S_DECODE: begin
                cls_d = w_cls;
                if (opcode == OP_SYSTEM)    state_d = S_HALT;
                else if (w_cls == CLS_NONE) state_d = S_ERROR;
                else                        state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_BRANCH:          state_d = w_br_ok ? S_FETCH : S_ERROR;
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    default:             state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready)                state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
                else if (timeout_q == TO_LAST) state_d = S_ERROR;
                else                           timeout_d = timeout_q + 1'b1;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = state_q;
        endcase
        // each wait window starts fresh when the access state is entered
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
            timeout_d = '0;
    end

    assign count_d = pc_write ? count_q + 1'b1 : count_q;

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'd0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        branch_lt  = 1'b0;
        branch_ge  = 1'b0;
        branch_u   = 1'b0;
        jump       = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_EXEC: begin
                if ((cls_q == CLS_BRANCH) && w_br_ok) begin
                    pc_write  = 1'b1;
                    branch_eq = (funct3 == 3'b000);
                    branch_ne = (funct3 == 3'b001);
                    branch_lt = funct3[2] & ~funct3[0];
                    branch_ge = funct3[2] &  funct3[0];
                    branch_u  = funct3[2] &  funct3[1];
                end
            end
            S_MEM: begin
                dmem_read  = (cls_q == CLS_LOAD);
                dmem_write = (cls_q == CLS_STORE);
                pc_write   = (cls_q == CLS_STORE) && dmem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (cls_q == CLS_LOAD)                              wb_sel = 2'd1;
                else if ((cls_q == CLS_JAL) || (cls_q == CLS_JALR)) wb_sel = 2'd2;
                jump     = (cls_q == CLS_JAL) || (cls_q == CLS_JALR);
                branch_u = (cls_q == CLS_JALR);
            end
            default: ;
        endcase
    end

    assign state         = state_q;
    assign halted        = (state_q == S_HALT);
    assign error         = (state_q == S_ERROR);
    assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Function : Directed and randomized check of multicycle_controller against an
//            instruction-level expectation model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_controller;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 16;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
    localparam logic [2:0] ST_MEM  = 3'd4, ST_WB    = 3'd5, ST_HALT   = 3'd6, ST_ERR  = 3'd7;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam int K_ILL = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JAL = 4, K_JALR = 5;
    localparam int K_SYS = 6, K_ALU = 7;

    // bit positions of the packed control bundle
    localparam int B_IREQ = 13, B_IRW = 12, B_PCW = 11, B_RW = 10, B_DR = 7, B_DW = 6;
    localparam int B_EQ = 5, B_NE = 4, B_LT = 3, B_GE = 2, B_U = 1, B_J = 0;

    logic clk = 1'b0, reset = 1'b0, run = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic imem_req, ir_write, pc_write, reg_write, dmem_read, dmem_write;
    logic branch_eq, branch_ne, branch_lt, branch_ge, branch_u, jump, halted, error;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic [CNT_W-1:0] retired_count;

    multicycle_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .branch_eq(branch_eq),
        .branch_ne(branch_ne), .branch_lt(branch_lt), .branch_ge(branch_ge),
        .branch_u(branch_u), .jump(jump), .state(state), .halted(halted), .error(error),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run, ir, dr;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [2:0]  st;
        logic [13:0] ctl;
        logic        hlt, err;
        logic [31:0] cnt;
    } vec_t;

    vec_t        q[$];
    logic [2:0]  obs[$];
    int          nvec = 0, nerr = 0;
    logic [31:0] m_cnt = '0;
    logic        m_halt = 1'b0, m_err = 1'b0, m_term = 1'b0;
    logic [6:0]  cur_opc = '0;
    logic [2:0]  cur_f3 = '0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int kind_of(input logic [6:0] o);
        case (o)
            OP_R, OP_I, OP_LUI, OP_AUI: return K_ALU;
            OP_LD:   return K_LD;
            OP_ST:   return K_ST;
            OP_BR:   return K_BR;
            OP_JAL:  return K_JAL;
            OP_JALR: return K_JALR;
            OP_SYS:  return K_SYS;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [13:0] ctl_now();
        return {imem_req, ir_write, pc_write, reg_write, wb_sel, dmem_read, dmem_write,
                branch_eq, branch_ne, branch_lt, branch_ge, branch_u, jump};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic rn, input logic ir, input logic dr,
                        input logic [13:0] c);
        vec_t v;
        v.run = rn; v.ir = ir; v.dr = dr; v.opc = cur_opc; v.f3 = cur_f3;
        v.st = st; v.ctl = c; v.hlt = m_halt; v.err = m_err; v.cnt = m_cnt;
        q.push_back(v);
    endtask

    task automatic terminate(input logic [2:0] st);
        m_term = 1'b1;
        m_halt = (st == ST_HALT);
        m_err  = (st == ST_ERR);
        repeat (3) push(st, rb(), rb(), rb(), '0);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, given ready delays.
    task automatic plan_instr(input logic [6:0] opc, input logic [2:0] f3,
                              input int idly, input int ddly);
        logic [13:0] c;
        logic        rdy;
        int          k, kind;
        cur_opc = opc; cur_f3 = f3;
        kind = kind_of(opc);
        k = 0;
        forever begin
            rdy = (k == idly);
            c = '0; c[B_IREQ] = 1'b1; c[B_IRW] = rdy;
            push(ST_FETCH, rb(), rdy, rb(), c);
            if (rdy) break;
            if (k == MEM_TIMEOUT - 1) begin terminate(ST_ERR); return; end
            k++;
        end
        push(ST_DECODE, rb(), rb(), rb(), '0);
        if (kind == K_SYS) begin terminate(ST_HALT); return; end
        if (kind == K_ILL) begin terminate(ST_ERR); return; end
        c = '0;
        if (kind == K_BR) begin
            case (f3)
                3'b000: c[B_EQ] = 1'b1;
                3'b001: c[B_NE] = 1'b1;
                3'b100: c[B_LT] = 1'b1;
                3'b101: c[B_GE] = 1'b1;
                3'b110: begin c[B_LT] = 1'b1; c[B_U] = 1'b1; end
                3'b111: begin c[B_GE] = 1'b1; c[B_U] = 1'b1; end
                default: begin push(ST_EXEC, rb(), rb(), rb(), '0); terminate(ST_ERR); return; end
            endcase
            c[B_PCW] = 1'b1;
            push(ST_EXEC, rb(), rb(), rb(), c);
            m_cnt++;
            return;
        end
        push(ST_EXEC, rb(), rb(), rb(), '0);
        if (kind == K_LD || kind == K_ST) begin
            k = 0;
            forever begin
                rdy = (k == ddly);
                c = '0; c[B_DR] = (kind == K_LD); c[B_DW] = (kind == K_ST);
                c[B_PCW] = (kind == K_ST) && rdy;
                push(ST_MEM, rb(), rb(), rdy, c);
                if (rdy) break;
                if (k == MEM_TIMEOUT - 1) begin terminate(ST_ERR); return; end
                k++;
            end
            if (kind == K_ST) begin m_cnt++; return; end
        end
        c = '0; c[B_RW] = 1'b1; c[B_PCW] = 1'b1;
        c[9:8] = (kind == K_LD) ? 2'd1 : ((kind == K_JAL || kind == K_JALR) ? 2'd2 : 2'd0);
        c[B_J] = (kind == K_JAL || kind == K_JALR);
        c[B_U] = (kind == K_JALR);
        push(ST_WB, rb(), rb(), rb(), c);
        m_cnt++;
    endtask

    task automatic apply(input vec_t v);
        logic [13:0] act;
        run = v.run; imem_ready = v.ir; dmem_ready = v.dr; opcode = v.opc; funct3 = v.f3;
        @(negedge clk);
        act = ctl_now();
        obs.push_back(state);
        nvec++;
        if (state !== v.st || act !== v.ctl || halted !== v.hlt || error !== v.err ||
            retired_count !== v.cnt) begin
            nerr++;
            $display("FAIL cycle_vec t=%0t: got st=%0d ctl=%b h=%b e=%b cnt=%0d, expected st=%0d ctl=%b h=%b e=%b cnt=%0d",
                     $time, state, act, halted, error, retired_count,
                     v.st, v.ctl, v.hlt, v.err, v.cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        while (q.size() > 0) apply(q.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outputs", 32'({ctl_now(), halted, error}), 32'd0);
        chk("rst_count", retired_count, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        m_cnt = '0; m_halt = 1'b0; m_err = 1'b0; m_term = 1'b0;
    endtask

    function automatic int dly();
        if ($urandom_range(0, 15) == 0) return $urandom_range(MEM_TIMEOUT - 2, MEM_TIMEOUT + 1);
        return $urandom_range(0, 3);
    endfunction

    logic [2:0] exp_addi[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    logic [6:0] ops[9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI};

    initial begin
        int n, r;
        logic [6:0] opc;

        // ADDI, BEQ, BGEU, LW, JALR, ECALL back to back
        do_reset();
        obs.delete();
        push(ST_IDLE, 1'b1, 1'b1, 1'b0, '0);
        plan_instr(OP_I, 3'd0, 0, 0);
        drain();
        chk("addi_len", 32'(obs.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs.size(); i++) chk("addi_seq", 32'(obs[i]), 32'(exp_addi[i]));
        chk("addi_next_state", 32'(state), 32'd1);
        chk("addi_retired", retired_count, 32'd1);
        obs.delete(); plan_instr(OP_BR, 3'b000, 0, 0); drain();
        chk("beq_len", 32'(obs.size()), 32'd3);
        plan_instr(OP_BR, 3'b111, 0, 0); drain();
        chk("bgeu_retired", retired_count, 32'd3);
        obs.delete(); plan_instr(OP_LD, 3'b010, 0, 3); drain();
        chk("lw_len", 32'(obs.size()), 32'd8);
        n = 0;
        foreach (obs[i]) if (obs[i] == ST_MEM) n++;
        chk("lw_mem_cycles", 32'(n), 32'd4);
        chk("lw_retired", retired_count, 32'd4);
        plan_instr(OP_JALR, 3'b000, 0, 0); drain();
        chk("jalr_retired", retired_count, 32'd5);
        plan_instr(OP_SYS, 3'b000, 0, 0); drain();
        chk("ecall_state", 32'(state), 32'd6);
        chk("ecall_halted", 32'(halted), 32'd1);
        chk("ecall_retired", retired_count, 32'd5);

        // instruction fetch never completes
        do_reset();
        obs.delete();
        push(ST_IDLE, 1'b1, 1'b0, 1'b0, '0);
        plan_instr(OP_I, 3'd0, 100, 0);
        drain();
        n = 0;
        foreach (obs[i]) if (obs[i] == ST_FETCH) n++;
        chk("timeout_fetch_cycles", 32'(n), 32'd16);
        chk("timeout_state", 32'(state), 32'd7);
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_imem_req", 32'(imem_req), 32'd0);

        // undefined opcode
        do_reset();
        push(ST_IDLE, 1'b1, 1'b0, 1'b0, '0);
        plan_instr(7'b1111111, 3'd0, 0, 0);
        drain();
        chk("illegal_state", 32'(state), 32'd7);

        // asynchronous reset in the middle of a store
        do_reset();
        push(ST_IDLE, 1'b1, 1'b0, 1'b0, '0);
        plan_instr(OP_I, 3'd0, 0, 0);
        drain();
        run = 1'b0; opcode = OP_ST; funct3 = 3'b010; imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sw_in_mem", 32'(state), 32'd4);
        chk("sw_dmem_write", 32'(dmem_write), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_dmem_write", 32'(dmem_write), 32'd0);
        chk("async_rst_count", retired_count, 32'd0);
        run = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_fetch", 32'(state), 32'd1);

        // randomized instruction streams
        for (int ep = 0; ep < 60; ep++) begin
            do_reset();
            cur_opc = 7'($urandom);
            repeat ($urandom_range(0, 2)) push(ST_IDLE, 1'b0, rb(), rb(), '0);
            push(ST_IDLE, 1'b1, rb(), rb(), '0);
            for (int i = 0; i < 12 && !m_term; i++) begin
                r = $urandom_range(0, 39);
                if (r < 36)      opc = ops[r % 9];
                else if (r < 38) opc = OP_SYS;
                else             opc = 7'($urandom);
                plan_instr(opc, 3'($urandom), dly(), dly());
                drain();
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
